mmu_wrr_arbiter: RTL

MMU_WRR_ARBITER -- requirements
Module: mmu_wrr_arbiter

---
 rtl/mmu_wrr_arbiter_pkg.sv | 49 ++++
 rtl/mmu_wrr_arbiter_seq.sv | 59 +++++
 rtl/mmu_wrr_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_wrr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lynxTypes -- shared types for the MMU weighted round-robin request arbiter.
//
// Holds the channel ceiling, the channel-id and weight typedefs, the arbiter
// FSM state encoding and two small helpers for the circular channel search.
// Channel vectors are padded to MMU_ARB_MAX_CHAN bits with zeros above N_CHAN.
// A 4-bit index can then wrap naturally modulo 16 and still visit the real
// channels in circular order.
// -----------------------------------------------------------------------------
package lynxTypes;

    localparam int MMU_ARB_MAX_CHAN     = 16;
    localparam int MMU_ARB_CHAN_BITS    = $clog2(MMU_ARB_MAX_CHAN);
    // Weights narrower than this are zero-extended into arb_wgt_t.
    localparam int MMU_ARB_MAX_WGT_BITS = 8;

    typedef logic [MMU_ARB_CHAN_BITS-1:0]    arb_chan_t;
    typedef logic [MMU_ARB_MAX_WGT_BITS-1:0] arb_wgt_t;
    typedef logic [MMU_ARB_MAX_CHAN-1:0]     arb_chan_vec_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_SERVE
    } arb_state_t;

    // First set bit of el at or above start, wrapping 15 -> 0.
    // This function returns start when el is empty; callers qualify with |el.
    function automatic arb_chan_t arb_first_from(arb_chan_vec_t el, arb_chan_t start);
        arb_chan_t idx;
        arb_chan_t pick;
        logic      found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < MMU_ARB_MAX_CHAN; k++) begin
            idx = start + arb_chan_t'(k);
            if (!found && el[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Increment a channel index, wrapping n_chan-1 back to 0.
    function automatic arb_chan_t arb_wrap_inc(arb_chan_t c, int n_chan);
        return (int'(c) >= n_chan - 1) ? arb_chan_t'(0) : c + arb_chan_t'(1);
    endfunction

endpackage

// File: rtl/mmu_wrr_arbiter_seq.sv
// -----------------------------------------------------------------------------
// mmu_arb_seq_fifo -- grant-order FIFO, first-word-fall-through.
//
// The FIFO records the source channel of every grant, in grant order.
//
// Ports
//   aclk, areset       clock, synchronous active-high reset (empties FIFO)
//   push, push_data    write one entry (caller guarantees !full or same-cycle pop)
//   pop_ready          consumer accepts the head entry
//   pop_valid          FIFO non-empty; pop_data is the head entry (0 when empty)
//   full               all DEPTH entries occupied
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module mmu_arb_seq_fifo #(
    parameter int DEPTH     = 32,
    parameter int DATA_BITS = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop_ready,
    output logic                 pop_valid,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 empty;
    logic                 pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && pop_ready;
    assign pop_valid = !empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; resetting the pointers empties the
    // FIFO, and the gated pop_data hides stale words.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmu_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_wrr_arbiter -- weighted round-robin arbiter for MMU request channels.
//
// N_CHAN request channels compete for one output slot. The winning
// descriptor is registered onto m_req_*. Its channel id is also queued in
// grant order on m_mux_* so that a downstream response mux can follow it.
// A channel with weight w receives up to w consecutive grants before the
// pointer moves on. A channel with weight 0 is disabled.
//
// Ports
//   aclk, areset                 clock, synchronous active-high reset
//   s_req_valid/ready/data       per-channel request handshake; ready is one-hot
//                                and high only in the grant cycle
//   cnfg_weight                  per-channel weights, WGT_BITS each (<= 8)
//   xfer_done                    per-channel completion pulse, returns one credit
//   m_req_valid/ready/data/id    granted descriptor, one cycle after the grant
//   m_mux_valid/ready/data       grant-order channel ids (SEQ_DEPTH-deep FIFO)
//   cred_err                     sticky: xfer_done arrived with nothing outstanding
//
// Configuration
//   MMU_ARB_CRED_EN  when defined, each channel may hold at most MAX_OUT
//                    ungranted-back requests, tracked by credit counters. When
//                    not defined, xfer_done is ignored and cred_err is tied to 0.
// -----------------------------------------------------------------------------
module mmu_wrr_arbiter
    import lynxTypes::*;
#(
    parameter int N_CHAN    = 4,
    parameter int REQ_BITS  = 96,
    parameter int WGT_BITS  = 4,
    parameter int MAX_OUT   = 16,
    parameter int SEQ_DEPTH = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [N_CHAN-1:0]            s_req_valid,
    output logic [N_CHAN-1:0]            s_req_ready,
    input  logic [N_CHAN*REQ_BITS-1:0]   s_req_data,
    input  logic [N_CHAN*WGT_BITS-1:0]   cnfg_weight,
    input  logic [N_CHAN-1:0]            xfer_done,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [REQ_BITS-1:0]          m_req_data,
    output logic [$clog2(N_CHAN)-1:0]    m_req_id,
    output logic                         m_mux_valid,
    input  logic                         m_mux_ready,
    output logic [$clog2(N_CHAN)-1:0]    m_mux_data,
    output logic [N_CHAN-1:0]            cred_err
);

    localparam int ID_BITS = $clog2(N_CHAN);

    arb_state_t          state, state_nxt;
    arb_chan_t           ptr, ptr_nxt, ptr_inc, sel;
    arb_wgt_t            bcnt, bcnt_nxt;
    arb_wgt_t            wgt [MMU_ARB_MAX_CHAN];
    arb_chan_vec_t       elig;
    logic [N_CHAN-1:0]   cred_ok;
    logic [REQ_BITS-1:0] sel_data;
    logic                slot_free, fifo_room, fifo_full, can_grant, any_elig;
    logic                burst_go, grant;

    // ------------------------------------------------------------------
    // Eligibility (padded to MMU_ARB_MAX_CHAN, unused channels stay 0)
    // ------------------------------------------------------------------
    always_comb begin
        elig = '0;
        for (int i = 0; i < MMU_ARB_MAX_CHAN; i++) wgt[i] = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            wgt[i][WGT_BITS-1:0] = cnfg_weight[i*WGT_BITS +: WGT_BITS];
            elig[i]              = s_req_valid[i] && (wgt[i] != '0) && cred_ok[i];
        end
    end

    // A full FIFO can still accept a push when its head is popped in the same cycle.
    assign slot_free = !m_req_valid || m_req_ready;
    assign fifo_room = !fifo_full || m_mux_ready;
    assign can_grant = slot_free && fifo_room && !areset;
    assign any_elig  = |elig;
    assign ptr_inc   = arb_wrap_inc(ptr, N_CHAN);
    // Mid-burst weight changes land here. A lowered weight below bcnt ends the burst.
    assign burst_go  = (state == ARB_SERVE) && elig[ptr] && (bcnt < wgt[ptr]);

    // ------------------------------------------------------------------
    // WRR FSM: state register + next-state/grant logic
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first; a path that missed an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        bcnt_nxt  = bcnt;
        grant     = 1'b0;
        sel       = burst_go ? ptr
                             : arb_first_from(elig, (state == ARB_IDLE) ? ptr : ptr_inc);
        case (state)
            ARB_IDLE: begin
                if (any_elig && can_grant) begin
                    grant     = 1'b1;
                    ptr_nxt   = sel;
                    bcnt_nxt  = arb_wgt_t'(1);
                    state_nxt = ARB_SERVE;
                end
            end
            ARB_SERVE: begin
                if (burst_go) begin
                    if (can_grant) begin
                        grant    = 1'b1;
                        bcnt_nxt = bcnt + arb_wgt_t'(1);
                    end
                end else if (any_elig) begin
                    if (can_grant) begin
                        grant    = 1'b1;
                        ptr_nxt  = sel;
                        bcnt_nxt = arb_wgt_t'(1);
                    end
                end else begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = ptr_inc;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Grant one-hot and descriptor mux.
    always_comb begin
        sel_data    = '0;
        s_req_ready = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (sel == arb_chan_t'(i)) begin
                sel_data       = s_req_data[i*REQ_BITS +: REQ_BITS];
                s_req_ready[i] = grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot: loaded on grant, held until m_req_ready.
    // ------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments so that every register
    // samples its pre-edge value, whatever the order of the statements.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_req_valid <= 1'b0;
            m_req_data  <= '0;
            m_req_id    <= '0;
        end else if (grant) begin
            m_req_valid <= 1'b1;
            m_req_data  <= sel_data;
            m_req_id    <= sel[ID_BITS-1:0];
        end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

    mmu_arb_seq_fifo #(
        .DEPTH     (SEQ_DEPTH),
        .DATA_BITS (ID_BITS)
    ) u_seq_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (grant),
        .push_data (sel[ID_BITS-1:0]),
        .pop_ready (m_mux_ready),
        .pop_valid (m_mux_valid),
        .pop_data  (m_mux_data),
        .full      (fifo_full)
    );

    // ------------------------------------------------------------------
    // Credit tracking
    // ------------------------------------------------------------------
`ifdef MMU_ARB_CRED_EN
    localparam int OUT_BITS = $clog2(MAX_OUT) + 1;

    logic [OUT_BITS-1:0] outst [N_CHAN];

    always_comb begin
        for (int i = 0; i < N_CHAN; i++) cred_ok[i] = (outst[i] < OUT_BITS'(MAX_OUT));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_CHAN; i++) outst[i] <= '0;
            cred_err <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                case ({s_req_ready[i], xfer_done[i]})
                    2'b10: outst[i] <= outst[i] + OUT_BITS'(1);
                    2'b01: begin
                        // A completion with nothing outstanding is a protocol error.
                        // The counter must not wrap.
                        if (outst[i] == '0) cred_err[i] <= 1'b1;
                        else                outst[i]    <= outst[i] - OUT_BITS'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    logic unused_xfer_done;

    assign cred_ok          = '1;
    assign cred_err         = '0;
    assign unused_xfer_done = ^xfer_done;
`endif

endmodule
